ahb_sram: RTL and testbench

AHB_SRAM -- requirements
Module: ahb_sram

---
 rtl/ahb_sram_pkg.sv | 32 +++
 rtl/ahb_byte_mask.sv | 20 ++
 rtl/ahb_sram.sv | 163 ++++++++++++++++
 tb/tb_ahb_sram.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_sram_pkg.sv
// Shared AHB-Lite encodings and byte-lane helpers for the SRAM bridge.
// Pure declarations: no latency, no flow control.
package ahb_sram_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_t;

    localparam int DATA_W  = 32;
    localparam int LANES   = DATA_W / 8;

    // Expands a 4-bit byte mask into a 32-bit bit mask.
    function automatic logic [DATA_W-1:0] lane_bits(input logic [LANES-1:0] mask);
        return {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    endfunction

    function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] base,
                                                      input logic [DATA_W-1:0] upd,
                                                      input logic [LANES-1:0]  mask);
        return (base & ~lane_bits(mask)) | (upd & lane_bits(mask));
    endfunction

endpackage

// File: rtl/ahb_byte_mask.sv
// Decodes HSIZE and the low address bits into active byte lanes.
// Combinational, zero latency, no backpressure.
module ahb_byte_mask
    import ahb_sram_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] addr_lo,
    output logic [3:0] mask
);

    always_comb begin
        mask = 4'b1111;
        case (hsize)
            HSIZE_BYTE: mask = 4'b0001 << addr_lo;
            HSIZE_HALF: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:    mask = 4'b1111;
        endcase
    end

endmodule

// File: rtl/ahb_sram.sv
// Zero-wait AHB-Lite to synchronous SRAM bridge; reads return data the cycle after accept,
// writes are posted into a small buffer and flushed on the next non-read cycle; HREADYOUT never stalls.
module ahb_sram
    import ahb_sram_pkg::*;
#(
    parameter int AW = 14
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          HSEL,
    input  logic [31:0]   HADDR,
    input  logic          HREADY,
    input  logic          HWRITE,
    input  logic [1:0]    HTRANS,
    input  logic [2:0]    HSIZE,
    input  logic [31:0]   HWDATA,
    output logic [31:0]   HRDATA,
    output logic          HREADYOUT,
    input  logic [31:0]   SRAMRDATA,
    output logic [3:0]    SRAMWEN,
    output logic [31:0]   SRAMWDATA,
    output logic          SRAMCS0,
    output logic [AW-3:0] SRAMADDR
);

    logic          acc, rd_acc, wr_acc, flush;
    logic [AW-3:0] haddr_w;
    logic [3:0]    acc_mask;
    logic [31:0]   wr_lanes;
    logic [31:0]   fwd_dat;

    logic          rd_pend;
    logic [AW-3:0] rd_addr;
    logic          wr_cap;
    logic [AW-3:0] wr_addr;
    logic [3:0]    wr_mask;

    // Two-entry posted-write buffer, entry 0 is the oldest and the one flushed.
    logic          b0_vld, b1_vld, n0_vld, n1_vld;
    logic [AW-3:0] b0_addr, b1_addr, n0_addr, n1_addr;
    logic [3:0]    b0_mask, b1_mask, n0_mask, n1_mask;
    logic [31:0]   b0_dat, b1_dat, n0_dat, n1_dat;

    assign haddr_w  = HADDR[AW-1:2];
    assign acc      = HRESETn & HSEL & HREADY & HTRANS[1];
    assign rd_acc   = acc & ~HWRITE;
    assign wr_acc   = acc & HWRITE;
    assign flush    = b0_vld & ~rd_acc;
    assign wr_lanes = HWDATA & lane_bits(wr_mask);

    ahb_byte_mask u_byte_mask (
        .hsize   (HSIZE),
        .addr_lo (HADDR[1:0]),
        .mask    (acc_mask)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rd_pend <= 1'b0;
            rd_addr <= '0;
            wr_cap  <= 1'b0;
            wr_addr <= '0;
            wr_mask <= 4'b0000;
        end else begin
            rd_pend <= rd_acc;
            wr_cap  <= wr_acc;
            if (rd_acc) begin
                rd_addr <= haddr_w;
            end
            if (wr_acc) begin
                wr_addr <= haddr_w;
                wr_mask <= acc_mask;
            end
        end
    end

    // A W,W,R sequence lands a second write while the first is held off by the read,
    // which is why the buffer needs two entries.
    always_comb begin
        n0_vld  = b0_vld;
        n0_addr = b0_addr;
        n0_mask = b0_mask;
        n0_dat  = b0_dat;
        n1_vld  = b1_vld;
        n1_addr = b1_addr;
        n1_mask = b1_mask;
        n1_dat  = b1_dat;
        if (flush) begin
            n0_vld  = b1_vld;
            n0_addr = b1_addr;
            n0_mask = b1_mask;
            n0_dat  = b1_dat;
            n1_vld  = 1'b0;
        end
        if (wr_cap) begin
            if (!n0_vld) begin
                n0_vld  = 1'b1;
                n0_addr = wr_addr;
                n0_mask = wr_mask;
                n0_dat  = wr_lanes;
            end else begin
                n1_vld  = 1'b1;
                n1_addr = wr_addr;
                n1_mask = wr_mask;
                n1_dat  = wr_lanes;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            b0_vld  <= 1'b0;
            b0_addr <= '0;
            b0_mask <= 4'b0000;
            b0_dat  <= '0;
            b1_vld  <= 1'b0;
            b1_addr <= '0;
            b1_mask <= 4'b0000;
            b1_dat  <= '0;
        end else begin
            b0_vld  <= n0_vld;
            b0_addr <= n0_addr;
            b0_mask <= n0_mask;
            b0_dat  <= n0_dat;
            b1_vld  <= n1_vld;
            b1_addr <= n1_addr;
            b1_mask <= n1_mask;
            b1_dat  <= n1_dat;
        end
    end

    always_comb begin
        SRAMCS0   = rd_acc | b0_vld;
        SRAMWEN   = flush ? b0_mask : 4'b0000;
        SRAMADDR  = rd_acc ? haddr_w : b0_addr;
        SRAMWDATA = b0_dat;
    end

    // Newer buffered lanes override older ones, both override the array.
    always_comb begin
        fwd_dat = SRAMRDATA;
        if (b0_vld && (b0_addr == rd_addr)) begin
            fwd_dat = merge_lanes(fwd_dat, b0_dat, b0_mask);
        end
        if (b1_vld && (b1_addr == rd_addr)) begin
            fwd_dat = merge_lanes(fwd_dat, b1_dat, b1_mask);
        end
        HRDATA = rd_pend ? fwd_dat : 32'h0;
    end

    assign HREADYOUT = 1'b1;

    logic unused_trans0;
    assign unused_trans0 = HTRANS[0];

    generate
        if (AW < 32) begin : g_unused_hi
            logic unused_haddr_hi;
            assign unused_haddr_hi = ^HADDR[31:AW];
        end
    endgenerate

endmodule

// File: tb/tb_ahb_sram.sv
// Randomized and directed bench for ahb_sram against an architectural memory model.
module tb_ahb_sram;

    localparam int AW = 14;
    localparam int NW = 1 << (AW - 2);

    typedef struct packed {
        logic [AW-3:0] addr;
        logic [3:0]    mask;
        logic [31:0]   dat;
    } wr_t;

    logic          HCLK      = 1'b0;
    logic          HRESETn   = 1'b0;
    logic          HSEL      = 1'b0;
    logic [31:0]   HADDR     = 32'h0;
    logic          HREADY    = 1'b1;
    logic          HWRITE    = 1'b0;
    logic [1:0]    HTRANS    = 2'b00;
    logic [2:0]    HSIZE     = 3'd0;
    logic [31:0]   HWDATA    = 32'h0;
    logic [31:0]   HRDATA;
    logic          HREADYOUT;
    logic [31:0]   SRAMRDATA = 32'h0;
    logic [3:0]    SRAMWEN;
    logic [31:0]   SRAMWDATA;
    logic          SRAMCS0;
    logic [AW-3:0] SRAMADDR;

    always #5 HCLK = ~HCLK;

    ahb_sram #(.AW(AW)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HREADY    (HREADY),
        .HWRITE    (HWRITE),
        .HTRANS    (HTRANS),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .SRAMRDATA (SRAMRDATA),
        .SRAMWEN   (SRAMWEN),
        .SRAMWDATA (SRAMWDATA),
        .SRAMCS0   (SRAMCS0),
        .SRAMADDR  (SRAMADDR)
    );

    function automatic logic [31:0] lanes(input logic [3:0] m);
        logic [31:0] r;
        r = 32'h0;
        for (int b = 0; b < 4; b++) begin
            if (m[b]) r = r | (32'hFF << (8 * b));
        end
        return r;
    endfunction

    function automatic logic [3:0] exp_mask(input logic [2:0] size, input logic [1:0] a);
        if (size == 3'd0) return 4'(1 << a);
        if (size == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] seed_val(input int i);
        return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A_5A5A;
    endfunction

    // Synchronous SRAM: registered read data, byte-masked writes.
    logic [31:0] sram [NW];
    bit          seeded = 1'b0;
    always @(posedge HCLK) begin
        if (!seeded) begin
            for (int i = 0; i < NW; i++) sram[i] <= seed_val(i);
            seeded <= 1'b1;
        end else if (SRAMCS0) begin
            if (SRAMWEN == 4'b0000) SRAMRDATA <= sram[SRAMADDR];
            else sram[SRAMADDR] <= (sram[SRAMADDR] & ~lanes(SRAMWEN)) | (SRAMWDATA & lanes(SRAMWEN));
        end
    end

    logic [31:0]   arch [NW];
    wr_t           wq[$];
    bit            p_rd, p_wr;
    logic [AW-3:0] p_addr;
    logic [3:0]    p_mask;
    logic [31:0]   nxt_wdata;
    int            n_vec = 0;
    int            n_err = 0;

    logic          obs_cs;
    logic [3:0]    obs_wen;
    logic [AW-3:0] obs_addr;
    logic [31:0]   obs_wdata, obs_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle: address phase from the arguments, data phase for the previously accepted write.
    task automatic bus(input bit sel, input logic [1:0] trans, input bit wr, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata, input bit rdy);
        bit  acc, push;
        wr_t ent, head;
        @(negedge HCLK);
        HSEL = sel; HTRANS = trans; HWRITE = wr; HSIZE = size;
        HADDR = addr; HREADY = rdy; HWDATA = nxt_wdata;
        acc  = sel && rdy && trans[1];
        push = 1'b0;
        ent  = '0;
        if (p_wr) begin
            ent.addr = p_addr;
            ent.mask = p_mask;
            ent.dat  = HWDATA & lanes(p_mask);
            arch[p_addr] = (arch[p_addr] & ~lanes(p_mask)) | ent.dat;
            push = 1'b1;
        end
        #4;
        obs_cs = SRAMCS0; obs_wen = SRAMWEN; obs_addr = SRAMADDR;
        obs_wdata = SRAMWDATA; obs_rdata = HRDATA;
        chk("hreadyout", 32'(HREADYOUT), 32'd1);
        chk("hrdata", HRDATA, p_rd ? arch[p_addr] : 32'h0);
        if (acc && !wr) begin
            chk("rd_cs", 32'(SRAMCS0), 32'd1);
            chk("rd_wen", 32'(SRAMWEN), 32'd0);
            chk("rd_addr", 32'(SRAMADDR), 32'(addr[AW-1:2]));
        end else if (wq.size() > 0) begin
            head = wq.pop_front();
            chk("wr_cs", 32'(SRAMCS0), 32'd1);
            chk("wr_wen", 32'(SRAMWEN), 32'(head.mask));
            chk("wr_addr", 32'(SRAMADDR), 32'(head.addr));
            chk("wr_data", SRAMWDATA & lanes(head.mask), head.dat);
        end else begin
            chk("idle_cs", 32'(SRAMCS0), 32'd0);
            chk("idle_wen", 32'(SRAMWEN), 32'd0);
        end
        if (push) wq.push_back(ent);
        p_rd      = acc && !wr;
        p_wr      = acc && wr;
        p_addr    = addr[AW-1:2];
        p_mask    = exp_mask(size, addr[1:0]);
        nxt_wdata = (acc && wr) ? wdata : $urandom();
    endtask

    task automatic idle();
        bus(1'b0, 2'b00, 1'b0, 3'd0, 32'h0, 32'h0, 1'b1);
    endtask

    task automatic wr(input logic [2:0] size, input logic [31:0] addr, input logic [31:0] data);
        bus(1'b1, 2'b10, 1'b1, size, addr, data, 1'b1);
    endtask

    task automatic rd(input logic [31:0] addr);
        bus(1'b1, 2'b10, 1'b0, 3'd2, addr, 32'h0, 1'b1);
    endtask

    initial begin
        logic [31:0] saved;
        int          n_diff;
        for (int i = 0; i < NW; i++) arch[i] = seed_val(i);
        p_rd = 1'b0; p_wr = 1'b0; p_addr = '0; p_mask = 4'b0; nxt_wdata = 32'h0;

        // Reset with a read request on the bus: nothing may reach the SRAM.
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h100;
        #4;
        chk("rst_cs", 32'(SRAMCS0), 32'd0);
        chk("rst_wen", 32'(SRAMWEN), 32'd0);
        chk("rst_hrdata", HRDATA, 32'h0);
        chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1; HSEL = 1'b0; HTRANS = 2'b00;

        // Word write then idle: flush in the second cycle.
        wr(3'd2, 32'h100, 32'hDEAD_BEEF);
        idle();
        idle();
        chk("w_word_wen", 32'(obs_wen), 32'hF);
        chk("w_word_addr", 32'(obs_addr), 32'h040);
        chk("w_word_data", obs_wdata, 32'hDEAD_BEEF);

        // Byte write forwarded into a back-to-back read of the same word.
        wr(3'd0, 32'h103, 32'h5500_0000);
        rd(32'h100);
        idle();
        chk("fwd_rdata", obs_rdata, 32'h55AD_BEEF);
        chk("fwd_flush_wen", 32'(obs_wen), 32'h8);

        // Write held off across three reads, issued in the first idle cycle.
        wr(3'd2, 32'h200, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            rd(32'h300);
            chk("hold_wen", 32'(obs_wen), 32'h0);
        end
        idle();
        chk("hold_flush_addr", 32'(obs_addr), 32'h080);
        chk("hold_flush_wen", 32'(obs_wen), 32'hF);
        chk("hold_flush_data", obs_wdata, 32'h1234_5678);

        // Halfword write to the upper half.
        wr(3'd1, 32'h402, 32'hAAAA_0000);
        idle();
        idle();
        chk("half_wen", 32'(obs_wen), 32'hC);
        chk("half_data", {16'h0, obs_wdata[31:16]}, 32'h0000_AAAA);

        // Back-to-back writes flush in order.
        wr(3'd2, 32'h0, 32'd1);
        wr(3'd2, 32'h4, 32'd2);
        wr(3'd2, 32'h8, 32'd3);
        chk("b2b0_addr", 32'(obs_addr), 32'd0);
        chk("b2b0_data", obs_wdata, 32'd1);
        idle();
        chk("b2b1_addr", 32'(obs_addr), 32'd1);
        chk("b2b1_data", obs_wdata, 32'd2);
        idle();
        chk("b2b2_addr", 32'(obs_addr), 32'd2);
        chk("b2b2_data", obs_wdata, 32'd3);

        // Random mix over a small window so reads and writes collide.
        for (int i = 0; i < 500; i++) begin
            logic [2:0]  sz;
            logic [31:0] a;
            bit          s, w, r;
            logic [1:0]  t;
            sz = 3'($urandom_range(0, 2));
            a  = 32'h100 + 32'($urandom_range(0, 31));
            a  = a & ~((32'd1 << sz) - 32'd1);
            s  = ($urandom_range(0, 3) != 0);
            t  = 2'($urandom_range(0, 3));
            w  = ($urandom_range(0, 1) == 1);
            r  = (p_rd || p_wr) ? 1'b1 : ($urandom_range(0, 7) != 0);
            bus(s, t, w, sz, a, $urandom(), r);
        end
        repeat (4) idle();

        // Reset while a write sits in the buffer: it must be dropped.
        saved = arch[12'h140];
        wr(3'd2, 32'h500, 32'hCAFE_F00D);
        rd(32'h600);
        @(negedge HCLK);
        HRESETn = 1'b0; HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h600;
        #4;
        chk("mid_rst_cs", 32'(SRAMCS0), 32'd0);
        chk("mid_rst_wen", 32'(SRAMWEN), 32'd0);
        chk("mid_rst_hrdata", HRDATA, 32'h0);
        chk("mid_rst_hreadyout", 32'(HREADYOUT), 32'd1);
        @(negedge HCLK);
        HRESETn = 1'b1; HSEL = 1'b0; HTRANS = 2'b00;
        wq.delete();
        p_rd = 1'b0; p_wr = 1'b0;
        arch[12'h140] = saved;
        repeat (4) idle();

        n_diff = 0;
        for (int i = 0; i < NW; i++) begin
            if (sram[i] !== arch[i]) n_diff++;
        end
        chk("mem_consistency", 32'(n_diff), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
